trgg_detect: RTL and testbench

//   Downstream consumer of the dual-channel trigger SPI front end (trgg). Takes the

---
 rtl/trgg_pkg.sv | 17 +
 rtl/trgg_chan.sv | 102 ++++++++++
 rtl/trgg_detect.sv | 107 ++++++++++
 tb/tb_trgg_detect.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trgg_pkg.sv
// Shared definitions for the trigger detect slice.
//   DW_DEF / DEB_W_DEF / TS_W_DEF : default sample, debounce-count and timestamp widths
//   chan_state_e                  : per-channel hysteresis/debounce state
package trgg_pkg;

  localparam int unsigned DW_DEF    = 16;
  localparam int unsigned DEB_W_DEF = 4;
  localparam int unsigned TS_W_DEF  = 32;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_PEND = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_PEND = 2'd3
  } chan_state_e;

endpackage

// File: rtl/trgg_chan.sv
// One trigger channel: hysteresis comparator plus debounce counter.
//   clk_i, rst_ni : clock, async active-low reset
//   smp_valid_i   : new sample strobe; state only advances when set
//   smp_i         : sample value (unsigned)
//   thr_hi_i      : rise threshold (sample >= thr_hi qualifies a rise)
//   thr_lo_i      : fall threshold (sample <= thr_lo qualifies a fall)
//   deb_len_i     : consecutive qualifying samples required (0 behaves as 1)
//   level_o       : registered debounced level
//   rise_o/fall_o : combinational 1-cycle pulses in the qualifying strobe cycle
module trgg_chan
  import trgg_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEB_W = DEB_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             smp_valid_i,
  input  logic [DW-1:0]    smp_i,
  input  logic [DW-1:0]    thr_hi_i,
  input  logic [DW-1:0]    thr_lo_i,
  input  logic [DEB_W-1:0] deb_len_i,
  output logic             level_o,
  output logic             rise_o,
  output logic             fall_o
);

  chan_state_e      state_q, state_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [DEB_W-1:0] deb_eff;
  logic [DEB_W:0]   cnt_inc;
  logic             done;
  logic             above;
  logic             below;

  assign deb_eff = (deb_len_i == '0) ? DEB_W'(1) : deb_len_i;
  assign cnt_inc = {1'b0, cnt_q} + (DEB_W + 1)'(1);
  // >= rather than == so a mid-debounce reduction of deb_len still completes
  assign done    = cnt_inc >= {1'b0, deb_eff};
  assign above   = smp_i >= thr_hi_i;
  assign below   = smp_i <= thr_lo_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q is 0 in LOW/HIGH, so cnt_inc=1 there and a deb_len of 1 passes the
  // PEND state within the same strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (smp_valid_i) begin
      unique case (state_q)
        ST_LOW, ST_RISE_PEND: begin
          if (above) begin
            if (done) begin
              state_d = ST_HIGH;
              cnt_d   = '0;
            end else begin
              state_d = ST_RISE_PEND;
              cnt_d   = cnt_inc[DEB_W-1:0];
            end
          end else begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end
        end
        ST_HIGH, ST_FALL_PEND: begin
          if (below) begin
            if (done) begin
              state_d = ST_LOW;
              cnt_d   = '0;
            end else begin
              state_d = ST_FALL_PEND;
              cnt_d   = cnt_inc[DEB_W-1:0];
            end
          end else begin
            state_d = ST_HIGH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    level_o = (state_q == ST_HIGH) || (state_q == ST_FALL_PEND);
    rise_o  = !level_o && (state_d == ST_HIGH);
    fall_o  = level_o && (state_d == ST_LOW);
  end

endmodule

// File: rtl/trgg_detect.sv
// Dual-channel trigger detector: per-channel hysteresis/debounce and a
// timestamped edge-event record handed out over valid/ready.
//   clk, rst_n        : clock, async active-low reset
//   trgg_data         : [2DW-1:DW] ch0 sample, [DW-1:0] ch1 sample
//   trgg_valid        : new sample pair strobe
//   thr_hi, thr_lo    : shared rise/fall thresholds
//   deb_len           : debounce length (0 behaves as 1)
//   trig_level        : debounced level, bit0 = ch0, bit1 = ch1
//   evt_valid/ready   : event record handshake
//   evt_chan/rise/ts  : record fields (channel, edge direction, strobe timestamp)
//   evt_ovf           : sticky drop flag, cleared by an accepted handshake
module trgg_detect
  import trgg_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEB_W = DEB_W_DEF,
  parameter int unsigned TS_W  = TS_W_DEF
) (
  input  logic [0:0]      clk,
  input  logic            rst_n,
  input  logic [2*DW-1:0] trgg_data,
  input  logic            trgg_valid,
  input  logic [DW-1:0]   thr_hi,
  input  logic [DW-1:0]   thr_lo,
  input  logic [DEB_W-1:0] deb_len,
  output logic [1:0]      trig_level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic            evt_chan,
  output logic            evt_rise,
  output logic [TS_W-1:0] evt_ts,
  output logic            evt_ovf
);

  logic [1:0]      rise, fall, ev;
  logic [TS_W-1:0] ts_q;
  logic            valid_q, valid_d;
  logic            chan_q, chan_d;
  logic            rise_q, rise_d;
  logic [TS_W-1:0] ts_evt_q, ts_evt_d;
  logic            ovf_q, ovf_d;
  logic            hs, can_load, drop;

  trgg_chan #(.DW(DW), .DEB_W(DEB_W)) u_ch0 (
    .clk_i(clk), .rst_ni(rst_n), .smp_valid_i(trgg_valid),
    .smp_i(trgg_data[2*DW-1:DW]), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
    .deb_len_i(deb_len), .level_o(trig_level[0]), .rise_o(rise[0]), .fall_o(fall[0])
  );

  trgg_chan #(.DW(DW), .DEB_W(DEB_W)) u_ch1 (
    .clk_i(clk), .rst_ni(rst_n), .smp_valid_i(trgg_valid),
    .smp_i(trgg_data[DW-1:0]), .thr_hi_i(thr_hi), .thr_lo_i(thr_lo),
    .deb_len_i(deb_len), .level_o(trig_level[1]), .rise_o(rise[1]), .fall_o(fall[1])
  );

  assign ev       = rise | fall;
  assign hs       = valid_q && evt_ready;
  assign can_load = !valid_q || hs;
  // ch1 loses arbitration when both fire; any event blocked by a held record is lost
  assign drop     = (&ev) || ((|ev) && !can_load);

  always_comb begin
    valid_d  = valid_q;
    chan_d   = chan_q;
    rise_d   = rise_q;
    ts_evt_d = ts_evt_q;
    ovf_d    = ovf_q;
    if ((|ev) && can_load) begin
      valid_d  = 1'b1;
      chan_d   = !ev[0];
      rise_d   = ev[0] ? rise[0] : rise[1];
      ts_evt_d = ts_q;
    end else if (hs) begin
      valid_d  = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (hs) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      valid_q  <= 1'b0;
      chan_q   <= 1'b0;
      rise_q   <= 1'b0;
      ts_evt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      rise_q   <= rise_d;
      ts_evt_q <= ts_evt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign evt_valid = valid_q;
  assign evt_chan  = chan_q;
  assign evt_rise  = rise_q;
  assign evt_ts    = ts_evt_q;
  assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_trgg_detect.sv
module tb_trgg_detect;

  logic        clk;
  logic        rst_n;
  logic [31:0] trgg_data;
  logic        trgg_valid;
  logic [15:0] thr_hi;
  logic [15:0] thr_lo;
  logic [3:0]  deb_len;
  logic [1:0]  trig_level;
  logic        evt_valid;
  logic        evt_ready;
  logic        evt_chan;
  logic        evt_rise;
  logic [31:0] evt_ts;
  logic        evt_ovf;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // reference model: level + run length per channel, one-slot event record
  bit          m_lvl[2];
  int unsigned m_cnt[2];
  bit          m_valid, m_chan, m_rise, m_ovf;
  logic [31:0] m_ts, m_tsc;

  trgg_detect #(.DW(16), .DEB_W(4), .TS_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .trgg_data(trgg_data), .trgg_valid(trgg_valid),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .deb_len(deb_len), .trig_level(trig_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan),
    .evt_rise(evt_rise), .evt_ts(evt_ts), .evt_ovf(evt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_valid = 1'b0; m_chan = 1'b0; m_rise = 1'b0; m_ovf = 1'b0;
    m_ts = '0; m_tsc = '0;
  endtask

  // Drive one cycle of inputs, advance the model by the same cycle, then clock.
  task automatic tick(input bit v, input logic [15:0] s0, input logic [15:0] s1, input bit rdy);
    bit          ev[2];
    bit          er[2];
    logic [15:0] s[2];
    int unsigned d;
    bit          hs, can, any;
    trgg_valid = v;
    trgg_data  = {s0, s1};
    evt_ready  = rdy;
    s[0] = s0; s[1] = s1;
    d = (deb_len == 0) ? 1 : int'(deb_len);
    for (int c = 0; c < 2; c++) begin
      ev[c] = 1'b0; er[c] = 1'b0;
      if (v) begin
        if (!m_lvl[c]) begin
          if (s[c] >= thr_hi) begin
            m_cnt[c]++;
            if (m_cnt[c] >= d) begin m_lvl[c] = 1'b1; m_cnt[c] = 0; ev[c] = 1'b1; er[c] = 1'b1; end
          end else m_cnt[c] = 0;
        end else begin
          if (s[c] <= thr_lo) begin
            m_cnt[c]++;
            if (m_cnt[c] >= d) begin m_lvl[c] = 1'b0; m_cnt[c] = 0; ev[c] = 1'b1; er[c] = 1'b0; end
          end else m_cnt[c] = 0;
        end
      end
    end
    hs  = m_valid && rdy;
    can = !m_valid || hs;
    any = ev[0] || ev[1];
    if (any && can) begin
      m_valid = 1'b1;
      m_chan  = ev[0] ? 1'b0 : 1'b1;
      m_rise  = ev[0] ? er[0] : er[1];
      m_ts    = m_tsc;
    end else if (hs) m_valid = 1'b0;
    if ((ev[0] && ev[1]) || (any && !can)) m_ovf = 1'b1;
    else if (hs) m_ovf = 1'b0;
    m_tsc = m_tsc + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trgg_valid = 1'b0; trgg_data = '0; evt_ready = 1'b0;
    thr_hi = 16'h8000; thr_lo = 16'h7000; deb_len = 4'd1;
    mdl_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({trig_level, evt_valid, evt_chan, evt_rise, evt_ovf} !== 6'b0 || evt_ts !== 32'd0)
      $display("FAIL reset_outputs got lvl=%b v=%b c=%b r=%b ovf=%b ts=%0d exp all 0",
               trig_level, evt_valid, evt_chan, evt_rise, evt_ovf, evt_ts);
    else n_pass++;
  endtask

  task automatic test_rise_deb3();
    do_reset();
    deb_len = 4'd3;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 16'h9000, 16'h0000, 1'b0);
      n_total++;
      if (trig_level !== ((i == 2) ? 2'b01 : 2'b00) || evt_valid !== (i == 2))
        $display("FAIL rise3_step%0d got lvl=%b v=%b exp lvl=%b v=%b", i, trig_level, evt_valid,
                 (i == 2) ? 2'b01 : 2'b00, (i == 2));
      else n_pass++;
    end
    n_total++;
    if (evt_chan !== 1'b0 || evt_rise !== 1'b1 || evt_ts !== 32'd2 || evt_ovf !== 1'b0)
      $display("FAIL rise3_record got c=%b r=%b ts=%0d ovf=%b exp c=0 r=1 ts=2 ovf=0",
               evt_chan, evt_rise, evt_ts, evt_ovf);
    else n_pass++;
  endtask

  task automatic test_glitch();
    logic [15:0] seq [4];
    do_reset();
    deb_len = 4'd3;
    seq[0] = 16'h9000; seq[1] = 16'h9000; seq[2] = 16'h6000; seq[3] = 16'h9000;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, seq[i], 16'h0000, 1'b0);
      n_total++;
      if (trig_level !== 2'b00 || evt_valid !== 1'b0)
        $display("FAIL glitch_step%0d got lvl=%b v=%b exp lvl=00 v=0", i, trig_level, evt_valid);
      else n_pass++;
    end
  endtask

  task automatic test_band_hold();
    do_reset();
    tick(1'b1, 16'h9000, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 16'h0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'h7800, 16'h0000, 1'b1);
      n_total++;
      if (trig_level !== 2'b01 || evt_valid !== 1'b0)
        $display("FAIL band_step%0d got lvl=%b v=%b exp lvl=01 v=0", i, trig_level, evt_valid);
      else n_pass++;
    end
  endtask

  task automatic test_both_same();
    do_reset();
    tick(1'b1, 16'h9000, 16'h9000, 1'b0);
    n_total++;
    if (trig_level !== 2'b11 || evt_valid !== 1'b1 || evt_chan !== 1'b0 ||
        evt_rise !== 1'b1 || evt_ovf !== 1'b1)
      $display("FAIL both_record got lvl=%b v=%b c=%b r=%b ovf=%b exp lvl=11 v=1 c=0 r=1 ovf=1",
               trig_level, evt_valid, evt_chan, evt_rise, evt_ovf);
    else n_pass++;
    tick(1'b0, 16'h0000, 16'h0000, 1'b0);
    n_total++;
    if (evt_valid !== 1'b1 || evt_ovf !== 1'b1 || evt_ts !== 32'd0)
      $display("FAIL both_hold got v=%b ovf=%b ts=%0d exp v=1 ovf=1 ts=0", evt_valid, evt_ovf, evt_ts);
    else n_pass++;
    tick(1'b0, 16'h0000, 16'h0000, 1'b1);
    n_total++;
    if (evt_valid !== 1'b0 || evt_ovf !== 1'b0)
      $display("FAIL both_accept got v=%b ovf=%b exp v=0 ovf=0", evt_valid, evt_ovf);
    else n_pass++;
  endtask

  task automatic test_deb0_reload();
    do_reset();
    deb_len = 4'd0;
    tick(1'b1, 16'hFFFF, 16'h0000, 1'b0);
    n_total++;
    if (trig_level !== 2'b01 || evt_valid !== 1'b1 || evt_rise !== 1'b1 || evt_chan !== 1'b0)
      $display("FAIL deb0_rise got lvl=%b v=%b r=%b c=%b exp lvl=01 v=1 r=1 c=0",
               trig_level, evt_valid, evt_rise, evt_chan);
    else n_pass++;
    tick(1'b1, 16'h0000, 16'h0000, 1'b1);
    n_total++;
    if (trig_level !== 2'b00 || evt_valid !== 1'b1 || evt_rise !== 1'b0 ||
        evt_ts !== 32'd1 || evt_ovf !== 1'b0)
      $display("FAIL deb0_fall_reload got lvl=%b v=%b r=%b ts=%0d ovf=%b exp lvl=00 v=1 r=0 ts=1 ovf=0",
               trig_level, evt_valid, evt_rise, evt_ts, evt_ovf);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 16'h0000, 16'h9000, 1'b0);
    deb_len = 4'd3;
    tick(1'b1, 16'h9000, 16'h9000, 1'b0);
    n_total++;
    if (trig_level !== 2'b10 || evt_valid !== 1'b1)
      $display("FAIL areset_pre got lvl=%b v=%b exp lvl=10 v=1", trig_level, evt_valid);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({trig_level, evt_valid, evt_chan, evt_rise, evt_ovf} !== 6'b0 || evt_ts !== 32'd0)
      $display("FAIL areset_clear got lvl=%b v=%b c=%b r=%b ovf=%b ts=%0d exp all 0",
               trig_level, evt_valid, evt_chan, evt_rise, evt_ovf, evt_ts);
    else n_pass++;
    mdl_reset();
    rst_n = 1'b1;
    tick(1'b1, 16'h9000, 16'h0000, 1'b0);
    tick(1'b1, 16'h9000, 16'h0000, 1'b0);
    n_total++;
    if (trig_level !== 2'b00 || evt_valid !== 1'b0)
      $display("FAIL areset_cnt_lost got lvl=%b v=%b exp lvl=00 v=0", trig_level, evt_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] s[2];
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 75 == 0) begin
        thr_lo  = 16'($urandom_range(0, 16'hFFFF));
        thr_hi  = 16'($urandom_range(int'(thr_lo), 16'hFFFF));
        deb_len = 4'($urandom_range(0, 4));
      end
      for (int c = 0; c < 2; c++) begin
        case ($urandom_range(0, 3))
          0: s[c] = thr_hi;
          1: s[c] = thr_lo;
          2: s[c] = 16'((int'(thr_hi) + int'(thr_lo)) / 2);
          default: s[c] = 16'($urandom);
        endcase
      end
      tick($urandom_range(0, 2) != 0, s[0], s[1], $urandom_range(0, 3) == 0);
      n_total++;
      if (trig_level !== {m_lvl[1], m_lvl[0]} || evt_valid !== m_valid || evt_ovf !== m_ovf ||
          (m_valid && (evt_chan !== m_chan || evt_rise !== m_rise || evt_ts !== m_ts)))
        $display("FAIL rnd_cyc%0d got lvl=%b v=%b ovf=%b c=%b r=%b ts=%0d exp lvl=%b v=%b ovf=%b c=%b r=%b ts=%0d",
                 cyc, trig_level, evt_valid, evt_ovf, evt_chan, evt_rise, evt_ts,
                 {m_lvl[1], m_lvl[0]}, m_valid, m_ovf, m_chan, m_rise, m_ts);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rise_deb3();
    test_glitch();
    test_band_hold();
    test_both_same();
    test_deb0_reload();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
